// File: rtl/montgomery_exp.sv
`default_nettype none
// ============================================================================
// Module   : montgomery_exp
// Function : X^E mod M by left-to-right square-and-multiply, driving an
//            external Montgomery multiplier one operation at a time, then a
//            final Mont(A,1) to return the result to the normal domain.
// Revision : 1.0 - initial release
// ============================================================================
module montgomery_exp #(
  parameter int WIDTH  = 512,
  parameter int E_BITS = 512,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_m,
  input  logic [E_BITS-1:0] in_e,
  output logic              mul_start,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  output logic [WIDTH-1:0]  mul_m,
  input  logic [WIDTH-1:0]  mul_result,
  input  logic              mul_done,
  output logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(E_BITS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    SQ_REQ    = 4'd2,
    SQ_WAIT   = 4'd3,
    MU_REQ    = 4'd4,
    MU_WAIT   = 4'd5,
    NEXT      = 4'd6,
    POST_REQ  = 4'd7,
    POST_WAIT = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  x_reg;
  logic [WIDTH-1:0]  m_reg;
  logic [E_BITS-1:0] e_reg;
  logic [CNT_W-1:0]  idx;
  // Set on every request; masks mul_done during the first wait cycle so a
  // done level left over from the previous multiplication is not captured.
  logic              guard;
  logic [E_BITS-1:0] e_shift;
  logic              e_bit;
  logic              mul_ok;

  assign e_shift = e_reg >> idx;
  assign e_bit   = e_shift[0];
  assign mul_ok  = mul_done && !guard;
  assign mul_m   = m_reg;

  // Control FSM with registered multiplier request, operands and status.
  // Operands are loaded on the edge entering each REQ state and left
  // untouched until the next request, keeping them stable through the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      x_reg     <= '0;
      m_reg     <= '0;
      e_reg     <= '0;
      idx       <= '0;
      guard     <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_reg <= in_x;
            a_reg <= in_r;
            m_reg <= in_m;
            e_reg <= in_e;
            idx   <= IDX_TOP;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          mul_start <= 1'b1;
          mul_a     <= a_reg;
          mul_b     <= a_reg;
          guard     <= 1'b1;
          state     <= SQ_REQ;
        end
        SQ_REQ: state <= SQ_WAIT;
        SQ_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (mul_ok) begin
            a_reg <= mul_result;
            if (e_bit) begin
              // Square result feeds the multiply directly as operand A.
              mul_start <= 1'b1;
              mul_a     <= mul_result;
              mul_b     <= x_reg;
              guard     <= 1'b1;
              state     <= MU_REQ;
            end else begin
              state <= NEXT;
            end
          end
        end
        MU_REQ: state <= MU_WAIT;
        MU_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (mul_ok) begin
            a_reg <= mul_result;
            state <= NEXT;
          end
        end
        NEXT: begin
          mul_start <= 1'b1;
          mul_a     <= a_reg;
          guard     <= 1'b1;
          if (idx == '0) begin
            mul_b <= ONE;
            state <= POST_REQ;
          end else begin
            idx   <= idx - 1'b1;
            mul_b <= a_reg;
            state <= SQ_REQ;
          end
        end
        POST_REQ: state <= POST_WAIT;
        POST_WAIT: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (mul_ok) begin
            result <= mul_result;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
